// File: rtl/fix_field_serializer.sv
// fix_field_serializer
// Takes whole FIX tag/value fields over a valid/ready handshake and streams
// "tag=value<SOH>" one byte per cycle under sink backpressure. It keeps a
// running mod-256 checksum of the body. On the last field it appends the
// "10=NNN<SOH>" trailer itself.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   field_valid_i/ready_o     field handshake (ready only in IDLE, not during abort)
//   tag_i, t_size_i           left-justified ASCII tag and its byte count
//   val_i, v_size_i           left-justified ASCII value and its byte count
//   last_i                    last body field; append the checksum trailer
//   abort_i                   abandon the current message
//   data_o/valid_o/ready_i    byte stream to the transport sink
//   sop_o, eop_o              first byte of message / final trailer SOH
//   checksum_o, byte_count_o  running body checksum and body byte count
//   size_err_o                one-cycle pulse when a field is dropped for bad size
//   msg_count_o               completed messages
//
// Build option: define FIX_MSG_COUNT_EN to count completed messages on
// msg_count_o. Without it, msg_count_o is tied to zero.
module fix_field_serializer #(
    parameter int unsigned TAG_BYTES     = 4,
    parameter int unsigned MAX_VAL_BYTES = 32,
    parameter int unsigned SIZE          = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       field_valid_i,
    output logic                       field_ready_o,
    input  logic [8*TAG_BYTES-1:0]     tag_i,
    input  logic [SIZE-1:0]            t_size_i,
    input  logic [8*MAX_VAL_BYTES-1:0] val_i,
    input  logic [SIZE-1:0]            v_size_i,
    input  logic                       last_i,
    input  logic                       abort_i,
    output logic [7:0]                 data_o,
    output logic                       data_valid_o,
    input  logic                       data_ready_i,
    output logic                       sop_o,
    output logic                       eop_o,
    output logic [7:0]                 checksum_o,
    output logic [15:0]                byte_count_o,
    output logic                       size_err_o,
    output logic [15:0]                msg_count_o
);

    localparam int unsigned TAG_W = 8 * TAG_BYTES;
    localparam int unsigned VAL_W = 8 * MAX_VAL_BYTES;

    typedef enum logic [2:0] {
        S_IDLE, S_TAG, S_EQ, S_VAL, S_SOH, S_CK_TAG, S_CK_DIG, S_CK_SOH
    } state_t;

    state_t            r_state;
    logic [TAG_W-1:0]  r_tag;
    logic [VAL_W-1:0]  r_val;
    logic [SIZE-1:0]   r_cnt;
    logic [SIZE-1:0]   r_vsize;
    logic              r_last;
    logic              r_in_msg;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_sop;
    logic              r_eop;
    logic [7:0]        r_cksum;
    logic [15:0]       r_bcount;
    logic              r_size_err;

    logic              w_bad_size;
    logic              w_xfer;
    logic              w_body;
    logic [7:0]        w_hund;
    logic [7:0]        w_rem;
    logic [7:0]        w_tens;
    logic [7:0]        w_ones;

    assign w_bad_size = (t_size_i == '0) || (32'(t_size_i) > TAG_BYTES) ||
                        (v_size_i == '0) || (32'(v_size_i) > MAX_VAL_BYTES);
    assign w_xfer     = r_valid && data_ready_i;
    assign w_body     = (r_state == S_TAG) || (r_state == S_EQ) ||
                        (r_state == S_VAL) || (r_state == S_SOH);

    // Decimal digits of the frozen checksum: compare-subtract for hundreds,
    // constant division for tens.
    always_comb begin
        w_hund = 8'd0;
        w_rem  = r_cksum;
        if (r_cksum >= 8'd200) begin
            w_hund = 8'd2;
            w_rem  = r_cksum - 8'd200;
        end else if (r_cksum >= 8'd100) begin
            w_hund = 8'd1;
            w_rem  = r_cksum - 8'd100;
        end
        w_tens = w_rem / 8'd10;
        w_ones = w_rem - 8'(w_tens * 8'd10);
    end

    assign field_ready_o = (r_state == S_IDLE) && !abort_i && !rst;

    // Field capture, byte sequencing, checksum and byte count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tag      <= '0;
            r_val      <= '0;
            r_cnt      <= '0;
            r_vsize    <= '0;
            r_last     <= 1'b0;
            r_in_msg   <= 1'b0;
            r_data     <= 8'd0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_cksum    <= 8'd0;
            r_bcount   <= 16'd0;
            r_size_err <= 1'b0;
        end else begin
            r_size_err <= 1'b0;
            if (abort_i) begin
                r_state  <= S_IDLE;
                r_valid  <= 1'b0;
                r_sop    <= 1'b0;
                r_eop    <= 1'b0;
                r_cksum  <= 8'd0;
                r_bcount <= 16'd0;
                r_in_msg <= 1'b0;
            end else if (r_state == S_IDLE) begin
                if (field_valid_i) begin
                    r_last <= last_i;
                    if (w_bad_size) begin
                        // Field dropped; a last flag still closes the message.
                        r_size_err <= 1'b1;
                        if (last_i) begin
                            r_state <= S_CK_TAG;
                            r_data  <= 8'h31;
                            r_cnt   <= SIZE'(2);
                            r_valid <= 1'b1;
                            r_sop   <= 1'b0;
                            if (!r_in_msg) begin
                                r_cksum  <= 8'd0;
                                r_bcount <= 16'd0;
                            end
                        end
                    end else begin
                        r_state  <= S_TAG;
                        r_data   <= tag_i[TAG_W-1 -: 8];
                        r_tag    <= tag_i << 8;
                        r_val    <= val_i;
                        r_cnt    <= t_size_i - SIZE'(1);
                        r_vsize  <= v_size_i;
                        r_valid  <= 1'b1;
                        r_sop    <= !r_in_msg;
                        r_in_msg <= 1'b1;
                        if (!r_in_msg) begin
                            r_cksum  <= 8'd0;
                            r_bcount <= 16'd0;
                        end
                    end
                end
            end else if (w_xfer) begin
                r_sop <= 1'b0;
                if (w_body) begin
                    r_cksum  <= r_cksum + r_data;
                    r_bcount <= r_bcount + 16'd1;
                end
                // r_cnt holds the number of bytes left in the current state.
                case (r_state)
                    S_TAG: begin
                        if (r_cnt != '0) begin
                            r_cnt  <= r_cnt - SIZE'(1);
                            r_data <= r_tag[TAG_W-1 -: 8];
                            r_tag  <= r_tag << 8;
                        end else begin
                            r_state <= S_EQ;
                            r_data  <= 8'h3D;
                        end
                    end
                    S_EQ: begin
                        r_state <= S_VAL;
                        r_data  <= r_val[VAL_W-1 -: 8];
                        r_val   <= r_val << 8;
                        r_cnt   <= r_vsize - SIZE'(1);
                    end
                    S_VAL: begin
                        if (r_cnt != '0) begin
                            r_cnt  <= r_cnt - SIZE'(1);
                            r_data <= r_val[VAL_W-1 -: 8];
                            r_val  <= r_val << 8;
                        end else begin
                            r_state <= S_SOH;
                            r_data  <= 8'h01;
                        end
                    end
                    S_SOH: begin
                        if (r_last) begin
                            r_state <= S_CK_TAG;
                            r_data  <= 8'h31;
                            r_cnt   <= SIZE'(2);
                        end else begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                    S_CK_TAG: begin
                        if (r_cnt == SIZE'(2)) begin
                            r_data <= 8'h30;
                            r_cnt  <= SIZE'(1);
                        end else if (r_cnt == SIZE'(1)) begin
                            r_data <= 8'h3D;
                            r_cnt  <= SIZE'(0);
                        end else begin
                            r_state <= S_CK_DIG;
                            r_data  <= 8'h30 + w_hund;
                            r_cnt   <= SIZE'(2);
                        end
                    end
                    S_CK_DIG: begin
                        if (r_cnt == SIZE'(2)) begin
                            r_data <= 8'h30 + w_tens;
                            r_cnt  <= SIZE'(1);
                        end else if (r_cnt == SIZE'(1)) begin
                            r_data <= 8'h30 + w_ones;
                            r_cnt  <= SIZE'(0);
                        end else begin
                            r_state <= S_CK_SOH;
                            r_data  <= 8'h01;
                            r_eop   <= 1'b1;
                        end
                    end
                    S_CK_SOH: begin
                        r_state  <= S_IDLE;
                        r_valid  <= 1'b0;
                        r_eop    <= 1'b0;
                        r_in_msg <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FIX_MSG_COUNT_EN
    logic [15:0] r_msg_cnt;

    // Counts eop transfers; an abort in the same cycle cancels the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msg_cnt <= 16'd0;
        end else if (!abort_i && w_xfer && r_eop) begin
            r_msg_cnt <= r_msg_cnt + 16'd1;
        end
    end

    assign msg_count_o = r_msg_cnt;
`else
    assign msg_count_o = 16'd0;
`endif

    assign data_o       = r_data;
    assign data_valid_o = r_valid;
    assign sop_o        = r_sop;
    assign eop_o        = r_eop;
    assign checksum_o   = r_cksum;
    assign byte_count_o = r_bcount;
    assign size_err_o   = r_size_err;

endmodule

// File: tb/tb_fix_field_serializer.sv
// Scoreboard bench for fix_field_serializer: a string-level model pushes the
// expected byte stream; a monitor pops on every transfer and compares.
module tb_fix_field_serializer;

    localparam int unsigned TAG_BYTES     = 4;
    localparam int unsigned MAX_VAL_BYTES = 32;
    localparam int unsigned SIZE          = 6;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  d;
        logic        sop;
        logic        eop;
        logic [7:0]  cs;
        logic [15:0] bc;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       field_valid_i;
    logic                       field_ready_o;
    logic [8*TAG_BYTES-1:0]     tag_i;
    logic [SIZE-1:0]            t_size_i;
    logic [8*MAX_VAL_BYTES-1:0] val_i;
    logic [SIZE-1:0]            v_size_i;
    logic                       last_i;
    logic                       abort_i;
    logic [7:0]                 data_o;
    logic                       data_valid_o;
    logic                       data_ready_i;
    logic                       sop_o;
    logic                       eop_o;
    logic [7:0]                 checksum_o;
    logic [15:0]                byte_count_o;
    logic                       size_err_o;
    logic [15:0]                msg_count_o;

    fix_field_serializer #(
        .TAG_BYTES(TAG_BYTES), .MAX_VAL_BYTES(MAX_VAL_BYTES), .SIZE(SIZE)
    ) dut (
        .clk(clk), .rst(rst),
        .field_valid_i(field_valid_i), .field_ready_o(field_ready_o),
        .tag_i(tag_i), .t_size_i(t_size_i), .val_i(val_i), .v_size_i(v_size_i),
        .last_i(last_i), .abort_i(abort_i),
        .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .sop_o(sop_o), .eop_o(eop_o), .checksum_o(checksum_o),
        .byte_count_o(byte_count_o), .size_err_o(size_err_o),
        .msg_count_o(msg_count_o)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_xfer = 0;
    int   m_cs = 0;
    int   m_bc = 0;
    int   m_mc = 0;
    bit   m_in_msg = 1'b0;
    int   rdy_mode = 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic bq_t s2q(input string s);
        bq_t r;
        for (int i = 0; i < s.len(); i++) r.push_back(8'(s[i]));
        return r;
    endfunction

    function automatic int exp_msg_count();
`ifdef FIX_MSG_COUNT_EN
        return m_mc % 65536;
`else
        return 0;
`endif
    endfunction

    // Reference model: builds "tag=value<SOH>" and the "10=NNN<SOH>" trailer.
    function automatic void model_field(input bq_t tg, input bq_t vl, input int tsz,
                                        input int vsz, input bit last);
        bit  err;
        bq_t body;
        bq_t tr;
        err = (tsz == 0) || (tsz > int'(TAG_BYTES)) || (vsz == 0) || (vsz > int'(MAX_VAL_BYTES));
        if (!err) begin
            for (int k = 0; k < tsz; k++) body.push_back(tg[k]);
            body.push_back(8'h3D);
            for (int k = 0; k < vsz; k++) body.push_back(vl[k]);
            body.push_back(8'h01);
            if (!m_in_msg) begin
                m_cs = 0;
                m_bc = 0;
            end
            for (int i = 0; i < body.size(); i++) begin
                q.push_back('{d: body[i], sop: (i == 0) && !m_in_msg, eop: 1'b0,
                              cs: 8'(m_cs), bc: 16'(m_bc)});
                m_cs = (m_cs + int'(body[i])) % 256;
                m_bc = (m_bc + 1) % 65536;
            end
            m_in_msg = 1'b1;
        end else if (last && !m_in_msg) begin
            m_cs = 0;
            m_bc = 0;
        end
        if (last) begin
            tr = '{8'h31, 8'h30, 8'h3D, 8'(48 + m_cs / 100), 8'(48 + (m_cs / 10) % 10),
                   8'(48 + m_cs % 10), 8'h01};
            for (int i = 0; i < 7; i++)
                q.push_back('{d: tr[i], sop: 1'b0, eop: (i == 6), cs: 8'(m_cs), bc: 16'(m_bc)});
            m_in_msg = 1'b0;
        end
    endfunction

    // Sink ready: 0 random, 1 always, 2 toggle every cycle.
    initial begin
        data_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       data_ready_i = ($urandom_range(0, 3) != 0);
                2:       data_ready_i = ~data_ready_i;
                default: data_ready_i = 1'b1;
            endcase
        end
    end

    // Monitor: pops one expected entry per transfer; checks hold during stalls.
    initial begin
        bit         stall_pending = 1'b0;
        logic [9:0] held = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst || abort_i) begin
                stall_pending = 1'b0;
            end else begin
                if (stall_pending && data_valid_o)
                    chk("stall_hold", {data_o, sop_o, eop_o}, held);
                stall_pending = 1'b0;
                if (data_valid_o && data_ready_i) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_byte: got 0x%0h expected no byte", data_o);
                    end else begin
                        e = q.pop_front();
                        chk("data", data_o, e.d);
                        chk("sop", sop_o, e.sop);
                        chk("eop", eop_o, e.eop);
                        chk("checksum", checksum_o, e.cs);
                        chk("byte_count", byte_count_o, e.bc);
                        n_xfer++;
                        if (e.eop) m_mc++;
                    end
                end else if (data_valid_o) begin
                    stall_pending = 1'b1;
                    held = {data_o, sop_o, eop_o};
                end
            end
        end
    end

    task automatic send_field(input bq_t tg, input bq_t vl, input int tsz, input int vsz,
                              input bit last);
        bit acc = 1'b0;
        bit err;
        err = (tsz == 0) || (tsz > int'(TAG_BYTES)) || (vsz == 0) || (vsz > int'(MAX_VAL_BYTES));
        @(posedge clk);
        #1;
        tag_i = {TAG_BYTES{8'($urandom_range(0, 255))}};
        val_i = {MAX_VAL_BYTES{8'($urandom_range(0, 255))}};
        for (int k = 0; k < tg.size() && k < int'(TAG_BYTES); k++)
            tag_i[8*(int'(TAG_BYTES)-k)-1 -: 8] = tg[k];
        for (int k = 0; k < vl.size() && k < int'(MAX_VAL_BYTES); k++)
            val_i[8*(int'(MAX_VAL_BYTES)-k)-1 -: 8] = vl[k];
        t_size_i = SIZE'(tsz);
        v_size_i = SIZE'(vsz);
        last_i = last;
        field_valid_i = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (field_ready_o) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        field_valid_i = 1'b0;
        if (!acc) begin
            n_chk++;
            $display("FAIL accept_timeout: got no accept expected accept within 5000 cycles");
        end else begin
            model_field(tg, vl, tsz, vsz, last);
            @(negedge clk);
            chk("size_err", size_err_o, err);
            chk("latency_valid", data_valid_o, !err || last);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !data_valid_o) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", done, 1);
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t r;
        for (int i = 0; i < n; i++) r.push_back(8'($urandom_range(33, 126)));
        return r;
    endfunction

    initial begin
        int x0;
        rst = 1'b1;
        field_valid_i = 1'b0;
        tag_i = '0;
        t_size_i = '0;
        val_i = '0;
        v_size_i = '0;
        last_i = 1'b0;
        abort_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_field_ready", field_ready_o, 0);
        chk("rst_data_valid", data_valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_sop_eop", {sop_o, eop_o}, 0);
        chk("rst_checksum", checksum_o, 0);
        chk("rst_byte_count", byte_count_o, 0);
        chk("rst_size_err", size_err_o, 0);
        chk("rst_msg_count", msg_count_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // "35"="0", last, sink always ready
        rdy_mode = 1;
        send_field(s2q("35"), s2q("0"), 2, 1, 1);
        wait_idle();
        chk("s1_checksum", checksum_o, 214);
        chk("s1_byte_count", byte_count_o, 5);
        chk("s1_msg_count", msg_count_o, exp_msg_count());

        // "1"="zzzzzzzz"
        send_field(s2q("1"), s2q("zzzzzzzz"), 1, 8, 1);
        wait_idle();
        chk("s2_checksum", checksum_o, 8'h3F);
        chk("s2_byte_count", byte_count_o, 11);

        // First scenario again with ready toggling
        rdy_mode = 2;
        x0 = n_xfer;
        send_field(s2q("35"), s2q("0"), 2, 1, 1);
        wait_idle();
        chk("s3_transfers", n_xfer - x0, 12);

        // Two-field message
        rdy_mode = 0;
        send_field(s2q("8"), s2q("FIX.4.2"), 1, 7, 0);
        send_field(s2q("35"), s2q("A"), 2, 1, 1);
        wait_idle();
        chk("s4_checksum", checksum_o, m_cs);

        // Dropped fields: zero and oversize value length
        send_field(s2q("58"), s2q("x"), 2, 0, 0);
        @(negedge clk);
        chk("size_err_one_cycle", size_err_o, 0);
        send_field(s2q("58"), rand_bytes(32), 2, 40, 0);
        wait_idle();
        chk("drop_checksum", checksum_o, m_cs);

        // Abort mid-value
        rdy_mode = 1;
        x0 = exp_msg_count();
        send_field(s2q("55"), rand_bytes(20), 2, 20, 1);
        repeat (6) @(posedge clk);
        #1;
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        q.delete();
        m_in_msg = 1'b0;
        m_cs = 0;
        m_bc = 0;
        @(negedge clk);
        chk("abort_valid", data_valid_o, 0);
        chk("abort_eop", eop_o, 0);
        chk("abort_checksum", checksum_o, 0);
        chk("abort_byte_count", byte_count_o, 0);
        chk("abort_msg_count", msg_count_o, x0);
        send_field(s2q("49"), s2q("SRV"), 2, 3, 1);
        wait_idle();
        chk("post_abort_msg_count", msg_count_o, exp_msg_count());

        // Abort and field_valid together: field is refused
        @(posedge clk);
        #1;
        abort_i = 1'b1;
        field_valid_i = 1'b1;
        t_size_i = SIZE'(1);
        v_size_i = SIZE'(1);
        @(negedge clk);
        chk("abort_blocks_ready", field_ready_o, 0);
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        field_valid_i = 1'b0;
        m_in_msg = 1'b0;
        m_cs = 0;
        m_bc = 0;
        @(negedge clk);
        chk("abort_no_accept", data_valid_o, 0);

        // Randomized fields
        rdy_mode = 0;
        for (int n = 0; n < 40; n++) begin
            int tsz = $urandom_range(1, TAG_BYTES);
            int vsz = $urandom_range(1, MAX_VAL_BYTES);
            bit err = ($urandom_range(0, 7) == 0);
            bit last;
            if (err) begin
                if ($urandom_range(0, 1) == 1)
                    tsz = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(TAG_BYTES + 1, 63);
                else
                    vsz = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_VAL_BYTES + 1, 63);
                last = m_in_msg && ($urandom_range(0, 1) == 1);
            end else begin
                last = ($urandom_range(0, 2) == 0);
            end
            send_field(rand_bytes(TAG_BYTES), rand_bytes(MAX_VAL_BYTES), tsz, vsz, last);
        end
        send_field(s2q("10"), s2q("end"), 2, 3, 1);
        wait_idle();
        chk("final_checksum", checksum_o, m_cs);
        chk("final_byte_count", byte_count_o, m_bc);
        chk("final_msg_count", msg_count_o, exp_msg_count());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fix_field_serializer.md
Name: fix_field_serializer

Overview:
Parametrised successor to the single-byte tag/value serializer behind the FIX session top level.
- Accepts whole tag/value fields over a valid/ready handshake.
- Emits the ASCII stream "tag=value<SOH>" one byte per cycle, with output backpressure.
- Keeps a running mod-256 checksum and, on the last field, appends the "10=NNN<SOH>" trailer itself.
- Sits between create_message and the transport byte sink.

Parameters:
- TAG_BYTES, 4, max ASCII tag length in bytes.
- MAX_VAL_BYTES, 32, max ASCII value length in bytes (VALUE_WIDTH = 8*MAX_VAL_BYTES).
- SIZE, 6, width of the size inputs; must satisfy 2^SIZE > MAX_VAL_BYTES.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- field_valid_i  in  1  field present.
- field_ready_o  out  1  field accepted when valid && ready.
- tag_i  in  8*TAG_BYTES  tag, left-justified; byte k = tag_i[8*(TAG_BYTES-k)-1 -: 8].
- t_size_i  in  SIZE  tag byte count.
- val_i  in  8*MAX_VAL_BYTES  value, left-justified, same byte order as tag_i.
- v_size_i  in  SIZE  value byte count.
- last_i  in  1  field is the last body field; append the checksum trailer.
- abort_i  in  1  abandon the current message.
- data_o  out  8  output byte.
- data_valid_o  out  1  data_o valid.
- data_ready_i  in  1  sink accepts data_o.
- sop_o  out  1  qualifies the first byte of a message.
- eop_o  out  1  qualifies the final SOH of the trailer.
- checksum_o  out  8  running sum mod 256.
- byte_count_o  out  16  body bytes emitted in the current message.
- size_err_o  out  1  one-cycle pulse: size 0 or size above maximum.
- msg_count_o  out  16  completed messages (see optional feature).

Behaviour:
- Reset (async, rst=1): state IDLE.
  - data_o=0, data_valid_o=0, sop_o=0, eop_o=0.
  - checksum_o=0, byte_count_o=0, size_err_o=0, msg_count_o=0.
  - field_ready_o=0 while rst is high.
- field_ready_o = (state==IDLE) && !abort_i. Tag, value, sizes and last_i are captured on accept.
- Latency: field accepted in cycle N, first byte presented (data_valid_o=1) in cycle N+1.
- Output handshake: a byte advances only when data_valid_o && data_ready_i. While stalled, data_o, sop_o and eop_o are held stable. No bubbles inside a field.
- States:
  - IDLE -> TAG: emit t_size tag bytes.
  - TAG -> EQ: emit 0x3D.
  - EQ -> VAL: emit v_size value bytes.
  - VAL -> SOH: emit 0x01.
  - SOH -> IDLE if !last, else -> CK_TAG.
  - CK_TAG: emit "10=" (0x31 0x30 0x3D).
  - CK_DIG: emit three zero-padded decimal digits of the frozen checksum.
  - CK_SOH: emit 0x01 with eop_o=1, then -> IDLE.
- Checksum:
  - Zeroed at sop.
  - Each body byte (TAG through SOH) is added mod 256 when it is transferred.
  - Frozen on entry to CK_TAG; trailer bytes are never added.
  - Decimal digits are computed by constant division or compare-subtract, no multi-cycle divider.
- byte_count_o:
  - Increments per transferred body byte.
  - Wraps at 2^16.
  - Cleared at the next message's sop.
  - Holds its value after eop.
- sop_o is asserted on the first tag byte of the first field after reset, after eop, or after abort.
- Size errors: t_size or v_size equal to 0, or greater than TAG_BYTES / MAX_VAL_BYTES, are still accepted. The field is dropped (nothing emitted, checksum unchanged) and size_err_o pulses. If last_i was set on the dropped field, the trailer is still emitted.
- abort_i: from any state, the next cycle enters IDLE.
  - data_valid_o drops and eop_o is not asserted.
  - checksum_o and byte_count_o clear; the next accepted field starts a new message with sop_o.
  - If abort_i and field_valid_i arrive together, abort wins and the field is not accepted.
- Reset mid-message: everything clears immediately and the partial message is lost.

Optional Feature:
- FIX_MSG_COUNT_EN defined: msg_count_o increments on each transferred eop byte and wraps at 2^16. Aborted or reset messages are not counted.
- Not defined: msg_count_o is tied to 0 and no counter is synthesised.

Test Plan:
- tag "35" (t_size 2), value "0" (v_size 1), last=1, data_ready_i=1 -> bytes 33 35 3D 30 01 31 30 3D 32 31 34 01.
  - First byte appears the cycle after accept, with sop_o.
  - Checksum 0xD6 (214); eop_o on the final 01; byte_count_o=5.
- tag "1", value "zzzzzzzz" (v_size 8), last=1 -> body sum 0x43F, checksum 0x3F, trailer digits "063" (30 36 33); byte_count_o=11.
- Same as the first scenario with data_ready_i toggling 1/0 every cycle -> identical byte sequence; data_o stable during stalls; 12 transfers total.
- Two fields ("8"="FIX.4.2", last=0; then "35"="A", last=1) -> sop_o only on the first '8'; trailer only after the second field; checksum covers both fields.
- v_size=0, last=0 -> size_err_o pulses once, no bytes emitted, checksum unchanged. Separately, v_size=40 with MAX_VAL_BYTES=32 -> same pulse and drop.
- abort_i asserted mid-VAL -> data_valid_o low the next cycle, no eop_o, checksum_o=0; the next field starts with sop_o. With FIX_MSG_COUNT_EN, msg_count_o is unchanged by the abort and increments by 1 after a completed message.
